// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to binary converter (reverse double dabble, one shift per clock).
// start/busy/done handshake; saturates to OUT_W bits with ovf, flags invalid digits with err.
module bcd_to_bin_seq #(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] bin,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned MaxVal = (1 << OUT_W) - 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e           state_q, state_d;
  logic [21:0]      sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [21:0]      step;
  logic [9:0]       val;
  logic             bad_digit;

  assign bad_digit = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

  // One reverse-dabble step: shift right, then correct each BCD nibble that reached >= 8.
  always_comb begin
    step = sr_q >> 1;
    for (int n = 0; n < 3; n++) begin
      if (step[10 + 4 * n + 3]) begin
        step[10 + 4 * n +: 4] = step[10 + 4 * n +: 4] - 4'd3;
      end
    end
  end

  assign val = step[9:0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {hundreds, tens, ones, 10'b0};
          cnt_d   = 4'd0;
          bin_d   = '0;
          ovf_d   = 1'b0;
          err_d   = bad_digit;
          state_d = bad_digit ? StDone : StConv;
        end
      end
      StConv: begin
        sr_d  = step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = StDone;
          if (32'(val) > MaxVal) begin
            bin_d = '1;
            ovf_d = 1'b1;
          end else begin
            bin_d = val[OUT_W-1:0];
            ovf_d = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == StConv);
  assign done = (state_q == StDone);
  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
